fifo_word_packer: RTL and testbench



---
 rtl/fifo_packer_pkg.sv | 11 +
 rtl/fifo_packer_timer.sv | 39 +++
 rtl/fifo_word_packer.sv | 108 ++++++++++
 tb/tb_fifo_word_packer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_packer_pkg.sv
// Shared types for the FIFO read-side word packer.
package fifo_packer_pkg;

   // IDLE: no lanes held, FILL: 1..Ratio-1 lanes held, HOLD: beat on the outputs
   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StHold
   } packer_state_e;

endpackage

// File: rtl/fifo_packer_timer.sv
// Saturating idle counter for the word packer. expired_o fires in the cycle whose
// increment brings the count up to TimeoutCycles.
module fifo_packer_timer #(
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);
   localparam logic [TmrW-1:0] TmrMax = TmrW'(TimeoutCycles);

   logic [TmrW-1:0] cnt_d, cnt_q;

   // Next count: clear wins, otherwise count up and saturate at TmrMax.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TmrMax)) begin
         cnt_d = cnt_q + TmrW'(1);
      end
   end

   assign expired_o = en_i && !clr_i && (cnt_d == TmrMax);

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs Ratio narrow FIFO words into one wide beat, lanes filled LSB first.
// Partial beats close on flush_i, or on an idle timeout when PACKER_TIMEOUT_EN
// is defined (without it, a partial beat waits for flush_i indefinitely).
module fifo_word_packer
   import fifo_packer_pkg::*;
#(
   parameter int unsigned InWidth       = 16,
   parameter int unsigned Ratio         = 4,
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [InWidth-1:0]       in_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [InWidth*Ratio-1:0] out_data_o,
   output logic [Ratio-1:0]         out_strb_o,
   output logic                     out_last_o,
   input  logic                     flush_i,
   output logic                     busy_o
);

   localparam int unsigned LaneW = $clog2(Ratio);
   localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

   packer_state_e              state_q;
   logic [LaneW-1:0]           cnt_q;
   logic [InWidth*Ratio-1:0]   data_q;
   logic [Ratio-1:0]           strb_q;
   logic                       last_q;
   logic                       accept;
   logic                       timeout_hit;

   assign accept = in_valid_i && (state_q != StHold);

`ifdef PACKER_TIMEOUT_EN
   // Timer only runs on FILL cycles without an accepted word.
   fifo_packer_timer #(
      .TimeoutCycles(TimeoutCycles)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    ((state_q != StFill) || accept),
      .en_i     ((state_q == StFill) && !accept),
      .expired_o(timeout_hit)
   );
`else
   logic unused_tmo;
   assign unused_tmo  = ^TimeoutCycles;
   assign timeout_hit = 1'b0;
`endif

   // Packer FSM; all outputs come straight from these registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StFill: begin
               if (accept) begin
                  data_q[int'(cnt_q)*InWidth +: InWidth] <= in_data_i;
                  strb_q[cnt_q]                          <= 1'b1;
                  if (cnt_q == LastLane) begin
                     // Full beat; cnt stays at the last lane until HOLD exit.
                     state_q <= StHold;
                     last_q  <= flush_i;
                  end else begin
                     cnt_q <= cnt_q + LaneW'(1);
                     if (flush_i) begin
                        state_q <= StHold;
                        last_q  <= 1'b1;
                     end else begin
                        state_q <= StFill;
                     end
                  end
               end else if ((state_q == StFill) && (flush_i || timeout_hit)) begin
                  state_q <= StHold;
                  last_q  <= 1'b1;
               end
            end
            StHold: begin
               if (out_ready_i) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  data_q  <= '0;
                  strb_q  <= '0;
                  last_q  <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o  = (state_q != StHold);
   assign out_valid_o = (state_q == StHold);
   assign busy_o      = (state_q != StIdle);
   assign out_data_o  = data_q;
   assign out_strb_o  = strb_q;
   assign out_last_o  = last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: stimulus pushes expected beats, a
// monitor pops and compares every beat handed downstream.
module tb_fifo_word_packer;

   localparam int unsigned InWidth       = 16;
   localparam int unsigned Ratio         = 4;
   localparam int unsigned TimeoutCycles = 8;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  strb;
      logic        last;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] in_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] out_data_o;
   logic [3:0]  out_strb_o;
   logic        out_last_o;
   logic        flush_i;
   logic        busy_o;

   int    tests = 0;
   int    fails = 0;
   beat_t exp_q[$];

   always #5 clk_i = ~clk_i;

   fifo_word_packer #(
      .InWidth      (InWidth),
      .Ratio        (Ratio),
      .TimeoutCycles(TimeoutCycles)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o (out_data_o),
      .out_strb_o (out_strb_o),
      .out_last_o (out_last_o),
      .flush_i    (flush_i),
      .busy_o     (busy_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_beat(input logic [63:0] d, input logic [3:0] s, input logic l);
      beat_t b;
      b.data = d;
      b.strb = s;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one word (optionally with flush) and hold it until accepted.
   task automatic send_word(input logic [15:0] d, input logic fl);
      bit ok;
      ok         = 1'b0;
      in_valid_i = 1'b1;
      in_data_i  = d;
      flush_i    = fl;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_i);
         if (in_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      check("send_accept_within_budget", {63'd0, ok}, 64'd1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      flush_i    = 1'b0;
      in_data_i  = '0;
   endtask

   // Monitor: every handed-off beat must match the head of the scoreboard.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk_i);
         if (rst_i === 1'b0 && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got data %h strb %h last %b, required no beat",
                        out_data_o, out_strb_o, out_last_o);
            end else begin
               b = exp_q.pop_front();
               check("beat_data", out_data_o, b.data);
               check("beat_strb", {60'd0, out_strb_o}, {60'd0, b.strb});
               check("beat_last", {63'd0, out_last_o}, {63'd0, b.last});
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;

      // Reset state
      check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
      check("rst_strb", {60'd0, out_strb_o}, 64'd0);
      check("rst_data", out_data_o, 64'd0);

      // Full beat, back-to-back words
      expect_beat(64'h4444_3333_2222_1111, 4'hF, 1'b0);
      send_word(16'h1111, 1'b0);
      check("fill_busy", {63'd0, busy_o}, 64'd1);
      send_word(16'h2222, 1'b0);
      send_word(16'h3333, 1'b0);
      send_word(16'h4444, 1'b0);
      check("full_latency_valid", {63'd0, out_valid_o}, 64'd1);
      check("full_in_ready_low", {63'd0, in_ready_o}, 64'd0);
      tick();
      check("full_drained_idle", {63'd0, busy_o}, 64'd0);

      // Backpressure: beat held, pending word (with flush) waits, then 1-lane beat
      out_ready_i = 1'b0;
      expect_beat(64'h0404_0303_0202_0101, 4'hF, 1'b0);
      send_word(16'h0101, 1'b0);
      send_word(16'h0202, 1'b0);
      send_word(16'h0303, 1'b0);
      send_word(16'h0404, 1'b0);
      expect_beat(64'h0000_0000_0000_5555, 4'h1, 1'b1);
      fork
         send_word(16'h5555, 1'b1);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk_i);
               check("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
               check("bp_valid", {63'd0, out_valid_o}, 64'd1);
               check("bp_data", out_data_o, 64'h0404_0303_0202_0101);
               check("bp_strb", {60'd0, out_strb_o}, 64'hF);
               check("bp_last", {63'd0, out_last_o}, 64'd0);
            end
            @(posedge clk_i);
            #1;
            out_ready_i = 1'b1;
         end
      join
      check("idle_flush_word_valid", {63'd0, out_valid_o}, 64'd1);
      tick();
      tick();

      // Flush a partial beat
      expect_beat(64'h0000_0000_BBBB_AAAA, 4'h3, 1'b1);
      send_word(16'hAAAA, 1'b0);
      send_word(16'hBBBB, 1'b0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_valid", {63'd0, out_valid_o}, 64'd1);
      check("flush_strb", {60'd0, out_strb_o}, 64'h3);
      tick();
      check("flush_drained", {63'd0, busy_o}, 64'd0);

      // Flush in IDLE without a word: no beat
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("idle_flush_no_valid", {63'd0, out_valid_o}, 64'd0);
      check("idle_flush_no_busy", {63'd0, busy_o}, 64'd0);
      tick();

      // Flush together with the completing word
      expect_beat(64'h0044_0033_0022_0011, 4'hF, 1'b1);
      send_word(16'h0011, 1'b0);
      send_word(16'h0022, 1'b0);
      send_word(16'h0033, 1'b0);
      send_word(16'h0044, 1'b1);
      check("flush_full_valid", {63'd0, out_valid_o}, 64'd1);
      tick();
      tick();

`ifdef PACKER_TIMEOUT_EN
      // Timeout closes after exactly TimeoutCycles idle FILL cycles
      expect_beat(64'h0000_000C_000B_000A, 4'h7, 1'b1);
      send_word(16'h000A, 1'b0);
      send_word(16'h000B, 1'b0);
      send_word(16'h000C, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("tmo_not_yet", {63'd0, out_valid_o}, 64'd0);
         tick();
      end
      check("tmo_fired", {63'd0, out_valid_o}, 64'd1);
      tick();
      tick();

      // A word in idle cycle 7 restarts the timer
      expect_beat(64'h0000_0000_00E2_00E1, 4'h3, 1'b1);
      send_word(16'h00E1, 1'b0);
      repeat (6) tick();
      check("tmo_restart_pre", {63'd0, out_valid_o}, 64'd0);
      send_word(16'h00E2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("tmo_restart_wait", {63'd0, out_valid_o}, 64'd0);
         tick();
      end
      check("tmo_restart_fired", {63'd0, out_valid_o}, 64'd1);
      tick();
      tick();
`else
      // Without the timer a partial beat persists until flushed
      expect_beat(64'h0000_000C_000B_000A, 4'h7, 1'b1);
      send_word(16'h000A, 1'b0);
      send_word(16'h000B, 1'b0);
      send_word(16'h000C, 1'b0);
      repeat (80) tick();
      check("notmo_no_valid", {63'd0, out_valid_o}, 64'd0);
      check("notmo_busy", {63'd0, busy_o}, 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("notmo_flush_valid", {63'd0, out_valid_o}, 64'd1);
      tick();
      tick();
`endif

      // Reset mid-beat discards the partial beat
      send_word(16'h0F01, 1'b0);
      send_word(16'h0F02, 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("midrst_busy", {63'd0, busy_o}, 64'd0);
      check("midrst_valid", {63'd0, out_valid_o}, 64'd0);
      check("midrst_in_ready", {63'd0, in_ready_o}, 64'd1);
      check("midrst_strb", {60'd0, out_strb_o}, 64'd0);
      expect_beat(64'h1004_1003_1002_1001, 4'hF, 1'b0);
      send_word(16'h1001, 1'b0);
      send_word(16'h1002, 1'b0);
      send_word(16'h1003, 1'b0);
      send_word(16'h1004, 1'b0);
      repeat (3) tick();

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
